// File: rtl/m_cp0.sv
// Coprocessor-0 exception/interrupt unit beside the M stage: SR, Cause, EPC, mfc0/mtc0, eret.
// Optional Count/Compare timer is built when the macro CP0_TIMER_EN is defined.
module m_cp0 (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        En,
    input  logic [4:0]  CP0Addr,
    input  logic [31:0] CP0In,
    output logic [31:0] CP0Out,
    input  logic [31:0] VPC,
    input  logic        BDIn,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic [31:0] EPCOut,
    output logic        Req
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;

    // SR image: IM[15:10], EXL[1], IE[0], everything else zero.
    function automatic logic [31:0] sr_word(input logic [5:0] im, input logic exl, input logic ie);
        sr_word = {16'd0, im, 8'd0, exl, ie};
    endfunction

    // Cause image: BD[31], IP[15:10], ExcCode[6:2], everything else zero.
    function automatic logic [31:0] cause_word(input logic bd, input logic [5:0] ip, input logic [4:0] code);
        cause_word = {bd, 15'd0, ip, 3'd0, code, 2'd0};
    endfunction

    logic [5:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic [5:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;

    logic [5:0]  im_nxt_s;
    logic        exl_nxt_s;
    logic        ie_nxt_s;
    logic        bd_nxt_s;
    logic [4:0]  exc_code_nxt_s;
    logic [31:0] epc_nxt_s;

    logic [5:0]  hw_eff_s;
    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic        wr_en_s;
    logic        sr_wr_s;
    logic        epc_wr_s;

    // An mtc0 only commits when the victim is not being squashed.
    assign wr_en_s  = En & ~req_s;
    assign sr_wr_s  = wr_en_s & (CP0Addr == ADDR_SR);
    assign epc_wr_s = wr_en_s & (CP0Addr == ADDR_EPC);

`ifdef CP0_TIMER_EN
    localparam logic [4:0] ADDR_COUNT   = 5'd9;
    localparam logic [4:0] ADDR_COMPARE = 5'd11;

    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic        timer_pend_r;
    logic [31:0] count_nxt_s;
    logic [31:0] compare_nxt_s;
    logic        timer_pend_nxt_s;
    logic        count_wr_s;
    logic        compare_wr_s;

    assign count_wr_s   = wr_en_s & (CP0Addr == ADDR_COUNT);
    assign compare_wr_s = wr_en_s & (CP0Addr == ADDR_COMPARE);
    assign hw_eff_s     = HWInt | {timer_pend_r, 5'd0};

    // Timer next state: free-running count, sticky match flag cleared by a Compare write.
    always_comb begin
        count_nxt_s      = count_r + 32'd1;
        compare_nxt_s    = compare_r;
        timer_pend_nxt_s = timer_pend_r;
        if (count_wr_s) begin
            count_nxt_s = CP0In;
        end else begin
            count_nxt_s = count_r + 32'd1;
        end
        if (compare_wr_s) begin
            compare_nxt_s    = CP0In;
            timer_pend_nxt_s = 1'b0;
        end else if ((count_r == compare_r) && (compare_r != 32'd0)) begin
            compare_nxt_s    = compare_r;
            timer_pend_nxt_s = 1'b1;
        end else begin
            compare_nxt_s    = compare_r;
            timer_pend_nxt_s = timer_pend_r;
        end
    end

    // Timer state registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_r      <= 32'd0;
            compare_r    <= 32'd0;
            timer_pend_r <= 1'b0;
        end else begin
            count_r      <= count_nxt_s;
            compare_r    <= compare_nxt_s;
            timer_pend_r <= timer_pend_nxt_s;
        end
    end
`else
    assign hw_eff_s = HWInt;
`endif

    assign int_req_s = ie_r & ~exl_r & (|(im_r & hw_eff_s));
    assign exc_req_s = ~exl_r & (ExcCodeIn != 5'd0);
    assign req_s     = int_req_s | exc_req_s;

    assign Req    = req_s;
    assign EPCOut = epc_r;

    // Next-state for SR/Cause/EPC; exception entry overrides any software write.
    always_comb begin
        im_nxt_s       = im_r;
        ie_nxt_s       = ie_r;
        exl_nxt_s      = exl_r;
        bd_nxt_s       = bd_r;
        exc_code_nxt_s = exc_code_r;
        epc_nxt_s      = epc_r;
        if (req_s) begin
            exl_nxt_s      = 1'b1;
            bd_nxt_s       = BDIn;
            exc_code_nxt_s = int_req_s ? 5'd0 : ExcCodeIn;
            epc_nxt_s      = BDIn ? (VPC - 32'd4) : VPC;
        end else begin
            if (sr_wr_s) begin
                im_nxt_s = CP0In[15:10];
                ie_nxt_s = CP0In[0];
            end else begin
                im_nxt_s = im_r;
                ie_nxt_s = ie_r;
            end
            // eret clears EXL after a same-cycle SR write.
            if (EXLClr) begin
                exl_nxt_s = 1'b0;
            end else if (sr_wr_s) begin
                exl_nxt_s = CP0In[1];
            end else begin
                exl_nxt_s = exl_r;
            end
            epc_nxt_s = epc_wr_s ? CP0In : epc_r;
        end
    end

    // SR/Cause/EPC registers; IP samples the interrupt lines every edge.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            im_r       <= 6'd0;
            exl_r      <= 1'b0;
            ie_r       <= 1'b0;
            bd_r       <= 1'b0;
            ip_r       <= 6'd0;
            exc_code_r <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            im_r       <= im_nxt_s;
            exl_r      <= exl_nxt_s;
            ie_r       <= ie_nxt_s;
            bd_r       <= bd_nxt_s;
            ip_r       <= hw_eff_s;
            exc_code_r <= exc_code_nxt_s;
            epc_r      <= epc_nxt_s;
        end
    end

    // mfc0 read mux, no write bypass.
    always_comb begin
        CP0Out = 32'd0;
        case (CP0Addr)
            ADDR_SR:      CP0Out = sr_word(im_r, exl_r, ie_r);
            ADDR_CAUSE:   CP0Out = cause_word(bd_r, ip_r, exc_code_r);
            ADDR_EPC:     CP0Out = epc_r;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   CP0Out = count_r;
            ADDR_COMPARE: CP0Out = compare_r;
`endif
            default:      CP0Out = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_m_cp0.sv
// Scoreboard bench for m_cp0: stimulus queues expectations, a negedge monitor pops and compares.
module tb_m_cp0;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        En;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] CP0Out;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] EPCOut;
    logic        Req;

    m_cp0 dut (
        .Clk(Clk), .Reset(Reset), .En(En), .CP0Addr(CP0Addr), .CP0In(CP0In),
        .CP0Out(CP0Out), .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn),
        .HWInt(HWInt), .EXLClr(EXLClr), .EPCOut(EPCOut), .Req(Req)
    );

    always #5 Clk = ~Clk;

    // kind: 0 = Req, 1 = CP0Out, 2 = EPCOut
    typedef struct {
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb_q[$];
    exp_t        mon_e;
    logic [31:0] mon_act;
    logic        probe = 1'b0;
    int          total = 0;
    int          bad = 0;

    always @(negedge Clk) begin
        if (probe) begin
            while (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                case (mon_e.kind)
                    0:       mon_act = {31'd0, Req};
                    1:       mon_act = CP0Out;
                    default: mon_act = EPCOut;
                endcase
                total = total + 1;
                if (mon_act !== mon_e.exp) begin
                    bad = bad + 1;
                    $display("FAIL %s: got %h expected %h", mon_e.name, mon_act, mon_e.exp);
                end
            end
        end
    end

    task automatic drive(input logic en, input logic [4:0] addr, input logic [31:0] din,
                         input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                         input logic [5:0] hw, input logic clr);
        En = en; CP0Addr = addr; CP0In = din; VPC = vpc;
        BDIn = bd; ExcCodeIn = exc; HWInt = hw; EXLClr = clr;
    endtask

    task automatic rd(input logic [4:0] addr, input logic [5:0] hw);
        drive(1'b0, addr, 32'd0, 32'd0, 1'b0, 5'd0, hw, 1'b0);
    endtask

    task automatic wr(input logic [4:0] addr, input logic [31:0] din);
        drive(1'b1, addr, din, 32'd0, 1'b0, 5'd0, 6'd0, 1'b0);
    endtask

    task automatic chk(input string n, input int k, input logic [31:0] v);
        exp_t e;
        e.name = n; e.kind = k; e.exp = v;
        sb_q.push_back(e);
        probe = 1'b1;
    endtask

    task automatic step;
        @(posedge Clk);
        #1;
        probe = 1'b0;
    endtask

    task automatic do_reset;
        rd(5'd0, 6'd0);
        Reset = 1'b1;
        step;
        Reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        rd(5'd0, 6'd0);
        step;
        step;
        Reset = 1'b0;

        // Reset state
        rd(5'd12, 6'd0); chk("rst_sr", 1, 32'h0); chk("rst_req", 0, 32'h0); chk("rst_epcout", 2, 32'h0);
        step;
        rd(5'd13, 6'd0); chk("rst_cause", 1, 32'h0);
        step;

        // mtc0 SR, no bypass in the write cycle
        wr(5'd12, 32'hFFFF_FFFF); chk("sr_nobypass", 1, 32'h0); chk("sr_wr_req", 0, 32'h0);
        step;
        rd(5'd12, 6'd0); EXLClr = 1'b1; chk("sr_all", 1, 32'h0000_FC03);
        step;
        rd(5'd12, 6'd0); chk("sr_exlclr", 1, 32'h0000_FC01); chk("sr_noint_req", 0, 32'h0);
        step;
        // writes to Cause and unimplemented registers are ignored
        wr(5'd13, 32'hFFFF_FFFF); step;
        wr(5'd15, 32'hFFFF_FFFF); step;
        rd(5'd13, 6'd0); chk("cause_ro", 1, 32'h0); step;
        rd(5'd15, 6'd0); chk("reg15_zero", 1, 32'h0); step;
`ifndef CP0_TIMER_EN
        wr(5'd9, 32'hFFFF_FFFF); step;
        rd(5'd9, 6'd0); chk("reg9_zero", 1, 32'h0); step;
`endif
        // Reset while Req is high: reset wins
        drive(1'b0, 5'd14, 32'd0, 32'h0000_5000, 1'b0, 5'd4, 6'd0, 1'b0);
        Reset = 1'b1; chk("rst_req_hi", 0, 32'h1);
        step;
        Reset = 1'b0;
        rd(5'd14, 6'd0); chk("rst_win_epc", 1, 32'h0); step;
        rd(5'd12, 6'd0); chk("rst_win_sr", 1, 32'h0); step;

        // Interrupt in a delay slot
        do_reset;
        wr(5'd12, 32'h0000_0401); step;
        drive(1'b0, 5'd14, 32'd0, 32'h0000_3010, 1'b1, 5'd0, 6'b000001, 1'b0);
        chk("ds_req", 0, 32'h1); chk("ds_epc_old", 1, 32'h0);
        step;
        rd(5'd14, 6'b000001); chk("ds_epc", 1, 32'h0000_300C); chk("ds_epcout", 2, 32'h0000_300C);
        chk("ds_exl_block", 0, 32'h0);
        step;
        rd(5'd13, 6'b000001); chk("ds_cause", 1, 32'h8000_0400); step;
        rd(5'd12, 6'b000001); chk("ds_sr", 1, 32'h0000_0403); step;

        // Exception and interrupt together: interrupt wins
        do_reset;
        wr(5'd12, 32'h0000_0401); step;
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3020, 1'b0, 5'd10, 6'b000001, 1'b0);
        chk("both_req", 0, 32'h1); step;
        rd(5'd13, 6'd0); chk("both_cause", 1, 32'h0000_0400); step;
        rd(5'd14, 6'd0); chk("both_epc", 1, 32'h0000_3020); step;
        // same with IE=0: exception recorded
        do_reset;
        wr(5'd12, 32'h0000_0400); step;
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3024, 1'b0, 5'd10, 6'b000001, 1'b0);
        chk("exc_req", 0, 32'h1); step;
        rd(5'd13, 6'd0); chk("exc_cause", 1, 32'h0000_0428); step;
        rd(5'd14, 6'd0); chk("exc_epc", 1, 32'h0000_3024); step;

        // mtc0 in the Req cycle is dropped
        do_reset;
        drive(1'b1, 5'd14, 32'h0000_1234, 32'h0000_3040, 1'b0, 5'd4, 6'd0, 1'b0);
        chk("mtc0req_req", 0, 32'h1); step;
        rd(5'd14, 6'd0); chk("mtc0req_epc", 1, 32'h0000_3040); step;
        rd(5'd13, 6'd0); chk("mtc0req_cause", 1, 32'h0000_0010); step;

        // Delay-slot EPC wraps modulo 2^32
        do_reset;
        drive(1'b0, 5'd0, 32'd0, 32'h0000_0002, 1'b1, 5'd12, 6'd0, 1'b0);
        chk("wrap_req", 0, 32'h1); step;
        rd(5'd14, 6'd0); chk("wrap_epc", 1, 32'hFFFF_FFFE); step;
        rd(5'd13, 6'd0); chk("wrap_cause", 1, 32'h8000_0030); step;

        // eret then re-arm, and mtc0 coinciding with eret
        do_reset;
        wr(5'd12, 32'h0000_0401); step;
        drive(1'b0, 5'd0, 32'd0, 32'h0000_3050, 1'b0, 5'd0, 6'b000001, 1'b0);
        chk("eret_take", 0, 32'h1); step;
        drive(1'b0, 5'd12, 32'd0, 32'd0, 1'b0, 5'd0, 6'b000001, 1'b1);
        chk("eret_blocked", 0, 32'h0); chk("eret_epcout", 2, 32'h0000_3050); chk("eret_sr", 1, 32'h0000_0403);
        step;
        rd(5'd12, 6'b000001); chk("rearm_req", 0, 32'h1); chk("rearm_sr", 1, 32'h0000_0401);
        step;
        drive(1'b1, 5'd12, 32'h0000_0403, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1);
        chk("wr_clr_req", 0, 32'h0); step;
        rd(5'd12, 6'd0); chk("wr_then_clr", 1, 32'h0000_0401); step;
        wr(5'd14, 32'hDEAD_BEEC); step;
        rd(5'd14, 6'd0); chk("epc_mtc0", 1, 32'hDEAD_BEEC); chk("epc_mtc0_out", 2, 32'hDEAD_BEEC); step;

`ifdef CP0_TIMER_EN
        // Timer: Req exactly 6 cycles after the Count write
        do_reset;
        wr(5'd11, 32'd5); step;
        wr(5'd12, 32'h0000_8001); step;
        wr(5'd9, 32'd0); step;
        for (int k = 0; k < 7; k++) begin
            rd(5'd9, 6'd0);
            chk($sformatf("tmr_req_%0d", k), 0, (k == 6) ? 32'h1 : 32'h0);
            chk($sformatf("tmr_cnt_%0d", k), 1, 32'(k));
            step;
        end
        rd(5'd13, 6'd0); chk("tmr_ip15", 1, 32'h0000_8000); step;
        wr(5'd11, 32'd5); step;
        rd(5'd13, 6'd0); step;
        rd(5'd13, 6'd0); chk("tmr_ip_clr", 1, 32'h0); step;
        drive(1'b0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0, 6'd0, 1'b1); step;
        rd(5'd0, 6'd0); chk("tmr_no_req", 0, 32'h0); step;
`endif

        rd(5'd0, 6'd0);
        step;
        if (sb_q.size() != 0) begin
            total = total + 1;
            bad = bad + 1;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/m_cp0.md
# m_cp0

Coprocessor-0 exception/interrupt unit for the five-stage MIPS pipeline, sitting beside the M stage. Each cycle it decides whether the instruction in M is taken by an exception or external interrupt and drives `Req`, which flushes every pipeline register, including the write-back register, and redirects fetch to the handler. It holds SR, Cause and EPC, serves `mfc0`/`mtc0`, and clears the exception level on `eret`.

## Interface
- No parameters.
- `Clk` input 1: clock, rising edge.
- `Reset` input 1: synchronous, active-high.
- `En` input 1: `mtc0` write enable, from M.
- `CP0Addr` input 5: CP0 register number for read and write.
- `CP0In` input 32: `mtc0` write data.
- `CP0Out` output 32: read data, combinational on `CP0Addr`.
- `VPC` input 32: PC of the victim instruction in M.
- `BDIn` input 1: victim is in a branch delay slot.
- `ExcCodeIn` input 5: synchronous exception code from M; 0 means none.
- `HWInt` input 6: external interrupt lines, level-sensitive.
- `EXLClr` input 1: `eret` in M.
- `EPCOut` output 32: current EPC, to the fetch redirect on `eret`.
- `Req` output 1: take exception or interrupt this cycle.

## Operation
- **SR (reg 12)**
  - Implemented bits: IM[15:10], EXL[1], IE[0].
  - All other bits read 0; writes to them are ignored.
- **Cause (reg 13)**
  - BD[31] and ExcCode[6:2] are written only on `Req`.
  - IP[15:10] is loaded from `HWInt` on every clock edge and is read-only.
  - All other bits read 0.
- **EPC (reg 14)**: full 32 bits, writable by `mtc0`.
- Any other address reads 0, and writes to it are ignored.
- **Request terms**
  - `IntReq` = IE & ~EXL & |(IM & HWInt).
  - `ExcReq` = ~EXL & (`ExcCodeIn` != 0).
  - `Req` = `IntReq` | `ExcReq`.
- **When `Req` is high, at the edge:**
  - EXL <= 1.
  - Cause.BD <= `BDIn`.
  - Cause.ExcCode <= `IntReq` ? 0 : `ExcCodeIn`. An interrupt takes priority over a simultaneous exception.
  - EPC <= `BDIn` ? `VPC`-4 : `VPC`. The subtraction is 32-bit modulo.
  - Any `mtc0` in the same cycle is dropped, because the victim does not commit.
- **When `EXLClr` is high and `Req` is low:** EXL <= 0 at the edge.
- **`mtc0`**: applies at the edge when `En` is high and `Req` is low. If it coincides with `EXLClr`, the EXL clear is applied after the `mtc0` write.
- **`CP0Out` bypass**: none. A write becomes readable in the cycle after the edge.
- **`EPCOut`**: the raw EPC register. An `eret` following `mtc0 EPC` is stalled by hazard control outside this block.

## Timing
- `Req`, `CP0Out` and `EPCOut` are combinational from the current inputs and registers; there is zero-cycle latency to `Req`.
- All state updates occur on the rising `Clk` edge.
- `Reset`: SR, Cause and EPC all clear to 0 on the edge.
  - The cycle after reset, `CP0Out` = 0 and `EPCOut` = 0.
  - `Req` follows `ExcCodeIn` only, since IE = 0 and EXL = 0.
- `Reset` asserted while `Req` is high: reset wins, and all registers go to 0.
- While EXL = 1, `Req` is held at 0 regardless of `HWInt` or `ExcCodeIn`. There are no nested exceptions.
- `HWInt` is sampled into IP with one cycle of delay. `IntReq` uses the live `HWInt`.

## Configuration
- Macro: `CP0_TIMER_EN`.
- **When defined:** Count (reg 9) and Compare (reg 11) are implemented, both 32 bits and both resetting to 0.
  - Count increments by 1 every cycle and wraps from 0xFFFFFFFF to 0.
  - An `mtc0` to Count loads the written value instead of incrementing.
  - A sticky `TimerPend` bit sets on the edge where Count == Compare and Compare != 0.
  - `TimerPend` clears on an `mtc0` to Compare and on `Reset`.
  - `TimerPend` is ORed into `HWInt[5]` wherever `HWInt` is used, in both `IntReq` and IP[15].
- **When undefined:** regs 9 and 11 read 0, writes to them are ignored, and no timer logic exists.

## Test plan
- **`mtc0` to SR**
  - Stimulus: after Reset, `En`=1, `CP0Addr`=12, `CP0In`=0xFFFF_FFFF.
  - Next cycle: reading reg 12 gives 0x0000_FC03.
  - Clear EXL with `EXLClr`=1; the following cycle reads 0x0000_FC01.
- **Interrupt in a delay slot**
  - Setup: SR=0x0000_0401.
  - Stimulus: `HWInt`=6'b000001, `VPC`=0x3010, `BDIn`=1.
  - Same cycle: `Req`=1.
  - Next cycle: EPC=0x300C, Cause[31]=1, ExcCode=0, EXL=1, and `Req`=0 even with `HWInt` still high.
- **Exception and interrupt together**
  - Setup: SR=0x0000_0401.
  - Stimulus: `ExcCodeIn`=10 with `HWInt`[0]=1.
  - Required: ExcCode=0 is recorded.
  - Repeat with IE=0: ExcCode=10 is recorded and EPC=`VPC`.
- **`mtc0` in the `Req` cycle**
  - Stimulus: `En`=1, `CP0Addr`=14, `CP0In`=0x1234, with `ExcCodeIn`=4 and `VPC`=0x3040.
  - Required: EPC=0x3040; the write is dropped.
- **`eret` then re-arm**
  - Setup: EXL=1.
  - Stimulus: `EXLClr`=1 for one cycle.
  - Required: EXL=0, and a pending masked-in `HWInt` raises `Req` in the very next cycle.
- **Timer (`CP0_TIMER_EN`)**
  - Stimulus: Compare=5, Count=0, SR=0x0000_8001.
  - Required: `Req`=1 exactly 6 cycles after the Count write.
  - Writing Compare clears the pending timer; without the macro, reg 9 reads 0.
